// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_pkg
// Purpose : Shared helpers for sync_fifo: depth computation and parameter
//           legality predicates, which the top level evaluates at elaboration.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Number of words held by a FIFO with the given address width.
    function automatic int fifo_depth(input int adsize);
        return 1 << adsize;
    endfunction

    // Almost-full threshold must lie in 1..DEPTH.
    function automatic bit af_level_ok(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    // Almost-empty threshold must lie in 0..DEPTH-1.
    function automatic bit ae_level_ok(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_ram
// Purpose : DEPTH x Dsize storage for sync_fifo. One synchronous write port,
//           one asynchronous read port. Contents are never reset.
// Ports   : clk      - clock
//           i_we     - write enable
//           i_waddr  - write address
//           i_wdata  - write data
//           i_raddr  - read address
//           o_rdata  - read data (combinational from i_raddr)
// Rev     : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
    parameter int Dsize  = 8,
    parameter int Adsize = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [Adsize-1:0] i_waddr,
    input  logic [Dsize-1:0]  i_wdata,
    input  logic [Adsize-1:0] i_raddr,
    output logic [Dsize-1:0]  o_rdata
);

    logic [Dsize-1:0] r_mem [0:(1<<Adsize)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : sync_fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with occupancy count, almost-full/almost-empty
//           thresholds and sticky overflow/underflow flags.
//           Build option SYNC_FIFO_FWFT_EN selects first-word-fall-through
//           reads; otherwise rd_data is registered with 1-cycle latency.
// Ports   : clk, rst (sync, active-high)
//           w_data, winc         - write data / request
//           rinc                 - read request (acknowledge in FWFT mode)
//           rd_data              - read data
//           wfull, rempty        - full / empty
//           walmost_full         - count >= AF_LEVEL
//           ralmost_empty        - count <= AE_LEVEL
//           count                - occupancy 0..DEPTH
//           overflow, underflow  - sticky error flags, cleared by rst only
// Rev     : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int Dsize    = 8,
    parameter int Adsize   = 4,
    parameter int AF_LEVEL = fifo_depth(Adsize) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Dsize-1:0]  w_data,
    input  logic              winc,
    input  logic              rinc,
    output logic [Dsize-1:0]  rd_data,
    output logic              wfull,
    output logic              rempty,
    output logic              walmost_full,
    output logic              ralmost_empty,
    output logic [Adsize:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH     = fifo_depth(Adsize);
    localparam logic [Adsize:0] c_DEPTH_CNT = (Adsize+1)'(c_DEPTH);
    localparam logic [Adsize:0] c_AF_CNT    = (Adsize+1)'(AF_LEVEL);
    localparam logic [Adsize:0] c_AE_CNT    = (Adsize+1)'(AE_LEVEL);
    localparam logic [Adsize:0] c_CNT_ONE   = (Adsize+1)'(1);
    localparam logic [Adsize-1:0] c_PTR_ONE = (Adsize)'(1);

    // Elaboration-time parameter legality.
    if (Adsize < 1) begin : g_bad_adsize
        $error("sync_fifo: Adsize must be >= 1");
    end
    if (!af_level_ok(AF_LEVEL, c_DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, c_DEPTH)) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [Adsize-1:0] r_wptr;
    logic [Adsize-1:0] r_rptr;
    logic [Adsize:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [Dsize-1:0]  w_mem_rdata;

    // Flags are pure decodes of the count register: no path from winc/rinc.
    assign rempty        = (r_count == '0);
    assign wfull         = (r_count == c_DEPTH_CNT);
    assign walmost_full  = (r_count >= c_AF_CNT);
    assign ralmost_empty = (r_count <= c_AE_CNT);
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    assign w_wr_en = winc & ~wfull;
    assign w_rd_en = rinc & ~rempty;

    sync_fifo_ram #(
        .Dsize  (Dsize),
        .Adsize (Adsize)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (w_data),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            // Simultaneous accepted read and write leave occupancy unchanged.
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Errors are judged on the raw requests against the current flags.
            if (winc & wfull) begin
                r_overflow <= 1'b1;
            end
            if (rinc & rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty.
    assign rd_data = rempty ? '0 : w_mem_rdata;
`else
    logic [Dsize-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= w_mem_rdata;
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_fifo
// Purpose : Self-checking bench for sync_fifo (DEPTH 4, AF 3, AE 1). A
//           queue-based reference model predicts every output after each
//           clock edge; directed steps follow the feature list, then a
//           randomized phase exercises arbitrary request mixes.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_DSIZE  = 8;
    localparam int c_ADSIZE = 2;
    localparam int c_DEPTH  = 4;
    localparam int c_AF     = 3;
    localparam int c_AE     = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [c_DSIZE-1:0]  w_data;
    logic                winc;
    logic                rinc;
    logic [c_DSIZE-1:0]  rd_data;
    logic                wfull;
    logic                rempty;
    logic                walmost_full;
    logic                ralmost_empty;
    logic [c_ADSIZE:0]   count;
    logic                overflow;
    logic                underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    logic [7:0] m_std_rd;
    bit         m_ovf;
    bit         m_unf;

    always #5 clk = ~clk;

    sync_fifo #(
        .Dsize    (c_DSIZE),
        .Adsize   (c_ADSIZE),
        .AF_LEVEL (c_AF),
        .AE_LEVEL (c_AE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_data        (w_data),
        .winc          (winc),
        .rinc          (rinc),
        .rd_data       (rd_data),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd_data();
`ifdef SYNC_FIFO_FWFT_EN
        return (m_q.size() == 0) ? 8'h00 : m_q[0];
`else
        return m_std_rd;
`endif
    endfunction

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"},   32'(count),         32'(n));
        chk({tag, ".rempty"},  32'(rempty),        32'(n == 0));
        chk({tag, ".wfull"},   32'(wfull),         32'(n == c_DEPTH));
        chk({tag, ".afull"},   32'(walmost_full),  32'(n >= c_AF));
        chk({tag, ".aempty"},  32'(ralmost_empty), 32'(n <= c_AE));
        chk({tag, ".ovf"},     32'(overflow),      32'(m_ovf));
        chk({tag, ".unf"},     32'(underflow),     32'(m_unf));
        chk({tag, ".rd_data"}, 32'(rd_data),       32'(model_rd_data()));
    endtask

    // One clock: apply inputs, advance model with pre-edge state, check after edge.
    task automatic cyc(input string tag, input bit r, input bit w, input bit rd,
                       input logic [7:0] d);
        bit full, empty;
        rst = r; winc = w; rinc = rd; w_data = d;
        full  = (m_q.size() == c_DEPTH);
        empty = (m_q.size() == 0);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_std_rd = 8'h00;
        end else begin
            if (w && full)  m_ovf = 1'b1;
            if (rd && empty) m_unf = 1'b1;
            if (rd && !empty) m_std_rd = m_q.pop_front();
            if (w && !full)   m_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; w_data = '0;
        m_std_rd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset held for two cycles.
        cyc("reset0", 1, 0, 0, 8'h00);
        cyc("reset1", 1, 0, 0, 8'h00);
        chk("reset.rd_data_zero", 32'(rd_data), 32'h0);
        chk("reset.rempty_one",   32'(rempty),  32'h1);

        // Fill to full.
        cyc("fill1", 0, 1, 0, 8'hA1);
        cyc("fill2", 0, 1, 0, 8'hA2);
        cyc("fill3", 0, 1, 0, 8'hA3);
        chk("fill3.afull_lit", 32'(walmost_full), 32'h1);
        cyc("fill4", 0, 1, 0, 8'hA4);
        chk("fill4.count_lit", 32'(count), 32'h4);
        chk("fill4.wfull_lit", 32'(wfull), 32'h1);

        // Overflow attempt, then drain.
        cyc("ovf", 0, 1, 0, 8'hA5);
        chk("ovf.flag_lit", 32'(overflow), 32'h1);
        cyc("idle", 0, 0, 0, 8'h00);
        chk("ovf.sticky_lit", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc("drain", 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain.word_lit", 32'(rd_data), 32'(8'hA1 + i));
`endif
        end

        // Underflow, then wrap with 10 write/read pairs.
        cyc("unf", 0, 0, 1, 8'h00);
        chk("unf.flag_lit", 32'(underflow), 32'h1);
        for (int i = 0; i < 10; i++) begin
            cyc("wrap.w", 0, 1, 0, 8'(i));
            cyc("wrap.r", 0, 0, 1, 8'h00);
        end

        // Simultaneous read/write at count 2, then at full.
        cyc("sim.pre1", 0, 1, 0, 8'h30);
        cyc("sim.pre2", 0, 1, 0, 8'h31);
        for (int i = 0; i < 6; i++) begin
            cyc("sim.rw", 0, 1, 1, 8'h40 + 8'(i));
        end
        cyc("sim.fill3", 0, 1, 0, 8'h50);
        cyc("sim.fill4", 0, 1, 0, 8'h51);
        cyc("sim.full_rw", 0, 1, 1, 8'h52);
        chk("full_rw.count_lit", 32'(count), 32'h3);

        // Mid-burst reset at count 3, then a single word round trip.
        cyc("mid.rst", 1, 1, 1, 8'hEE);
        chk("mid.count_lit", 32'(count), 32'h0);
        cyc("mid.w", 0, 1, 0, 8'h5C);
`ifdef SYNC_FIFO_FWFT_EN
        chk("mid.fwft_lit", 32'(rd_data), 32'h5C);
`endif
        cyc("mid.r", 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        chk("mid.std_lit", 32'(rd_data), 32'h5C);
`endif

        // Randomized phase with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
